// File: rtl/morph_pkg.sv
// Shared types and helpers for the 5x5 morphology stream kernels.
// Pixel defaults, pad value, frame FSM states and a clog2 helper.
package morph_pkg;

    localparam int DW_DEF = 8;

    typedef logic [DW_DEF-1:0] pixel_t;

    localparam int PAD_VAL = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/morph_max25.sv
// Combinational 25-input max (or min when IS_MIN) reduction, DW wide.
// Used by the 5x5 dilation stream; the min flavour backs the gradient output.
module morph_max25 #(
    parameter int DW     = 8,
    parameter bit IS_MIN = 1'b0
) (
    input  logic [24:0][DW-1:0] px_i,
    output logic [DW-1:0]       y_o
);

    always_comb begin
        y_o = px_i[0];
        for (int i = 1; i < 25; i++) begin
            if (IS_MIN ? (px_i[i] < y_o) : (px_i[i] > y_o)) y_o = px_i[i];
        end
    end

endmodule

// File: rtl/morph_dilate_5x5_stream.sv
// Streaming 5x5 grey-scale dilation with zero padding, one output per input.
// Define MORPH_DILATE_GRADIENT_EN to add the 5x5 min tree and m_grad output.
module morph_dilate_5x5_stream
    import morph_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          busy
`ifdef MORPH_DILATE_GRADIENT_EN
   ,output logic [DW-1:0] m_grad
`endif
);

    localparam int VCW = clog2(IMG_W + 2);
    localparam int VRW = clog2(IMG_H + 4);
    localparam int AW  = clog2(IMG_W);

    localparam logic [VCW-1:0] COL_LAST = VCW'(IMG_W - 1);
    localparam logic [VCW-1:0] COL_PAD0 = VCW'(IMG_W);
    localparam logic [VCW-1:0] COL_PAD1 = VCW'(IMG_W + 1);
    localparam logic [VRW-1:0] ROW_LAST = VRW'(IMG_H - 1);
    localparam logic [VRW-1:0] ROW_PAD1 = VRW'(IMG_H + 1);
    localparam logic [VRW-1:0] ROW_END  = VRW'(IMG_H + 2);
    localparam logic [DW-1:0]  PAD      = DW'(PAD_VAL);

    state_t         state_q, state_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic [VRW-1:0] vr_q, vr_d;
    logic           init_q;
    logic           en, push;
    logic [DW-1:0]  px_in;
    logic [AW-1:0]  la;

    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb2 [IMG_W];
    logic [DW-1:0] lb3 [IMG_W];

    logic [DW-1:0] col [5];
    logic [4:0]    col_v;
    logic [DW-1:0] win_q [5][5];
    logic [4:0]    wv_q  [5];

    logic tag_v, tag_sof, tag_eol, tag_last;
    logic w_v_q, w_sof_q, w_eol_q, w_last_q;
    logic x_v_q, x_sof_q, x_eol_q, x_last_q;
    logic m_valid_q, m_sof_q, m_eol_q, m_last_q;

    logic [24:0][DW-1:0] mx_in;
    logic [DW-1:0]       mx, mx_q, m_data_q;

    assign en      = !m_valid_q || m_ready;
    assign la      = vc_q[AW-1:0];
    assign busy    = (state_q != IDLE);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sof   = m_sof_q;
    assign m_eol   = m_eol_q;

    always_comb begin
        state_d = state_q;
        vc_d    = vc_q;
        vr_d    = vr_q;
        s_ready = 1'b0;
        push    = 1'b0;
        px_in   = PAD;
        unique case (state_q)
            IDLE: begin
                s_ready = init_q && en;
                if (s_ready && s_valid && s_sof) begin
                    push    = 1'b1;
                    px_in   = s_data;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_ready = en && (vc_q < COL_PAD0);
                if (s_ready && s_valid) begin
                    push  = 1'b1;
                    px_in = s_data;
                end else if (en && (vc_q >= COL_PAD0)) begin
                    push = 1'b1;
                end
                if (push && vr_q == ROW_LAST && vc_q == COL_LAST)
                    state_d = FLUSH;
            end
            FLUSH: begin
                push = en && (vr_q != ROW_END);
                if (m_valid_q && m_ready && m_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            if (vc_q == COL_PAD1) begin
                vc_d = '0;
                vr_d = vr_q + VRW'(1);
            end else begin
                vc_d = vc_q + VCW'(1);
            end
        end
        if (state_q == FLUSH && state_d == IDLE) begin
            vc_d = '0;
            vr_d = '0;
        end
    end

    // Column vector, top row (vr-4) first; rows outside the image are masked.
    always_comb begin
        col[0] = lb3[la];
        col[1] = lb2[la];
        col[2] = lb1[la];
        col[3] = lb0[la];
        col[4] = px_in;
        for (int i = 0; i < 5; i++) begin
            col_v[i] = (vc_q < COL_PAD0)
                    && (vr_q >= VRW'(4 - i))
                    && (vr_q <= VRW'(IMG_H + 3 - i));
        end
    end

    assign tag_v    = (vr_q >= VRW'(2)) && (vc_q >= VCW'(2));
    assign tag_sof  = (vr_q == VRW'(2)) && (vc_q == VCW'(2));
    assign tag_eol  = (vc_q == COL_PAD1);
    assign tag_last = (vr_q == ROW_PAD1) && (vc_q == COL_PAD1);

    always_ff @(posedge clk) begin
        if (push && (vc_q < COL_PAD0)) begin
            lb0[la] <= px_in;
            lb1[la] <= lb0[la];
            lb2[la] <= lb1[la];
            lb3[la] <= lb2[la];
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                mx_in[i*5+j] = wv_q[i][j] ? win_q[i][j] : PAD;
    end

    morph_max25 #(.DW(DW), .IS_MIN(1'b0)) u_max (
        .px_i (mx_in),
        .y_o  (mx)
    );

`ifdef MORPH_DILATE_GRADIENT_EN
    logic [24:0][DW-1:0] mn_in;
    logic [DW-1:0]       mn, mn_q, m_grad_q;

    // Out-of-image taps must never win the min, so they read as all-ones.
    always_comb begin
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                mn_in[i*5+j] = wv_q[i][j] ? win_q[i][j] : {DW{1'b1}};
    end

    morph_max25 #(.DW(DW), .IS_MIN(1'b1)) u_min (
        .px_i (mn_in),
        .y_o  (mn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mn_q     <= '0;
            m_grad_q <= '0;
        end else if (en) begin
            mn_q     <= mn;
            m_grad_q <= mx_q - mn_q;
        end
    end

    assign m_grad = m_grad_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vc_q      <= '0;
            vr_q      <= '0;
            init_q    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                wv_q[i] <= '0;
                for (int j = 0; j < 5; j++) win_q[i][j] <= '0;
            end
            w_v_q     <= 1'b0;
            w_sof_q   <= 1'b0;
            w_eol_q   <= 1'b0;
            w_last_q  <= 1'b0;
            x_v_q     <= 1'b0;
            x_sof_q   <= 1'b0;
            x_eol_q   <= 1'b0;
            x_last_q  <= 1'b0;
            mx_q      <= '0;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            init_q  <= 1'b1;
            state_q <= state_d;
            vc_q    <= vc_d;
            vr_q    <= vr_d;
            if (en) begin
                if (push) begin
                    for (int i = 0; i < 5; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            win_q[i][j] <= win_q[i][j+1];
                            wv_q[i][j]  <= wv_q[i][j+1];
                        end
                        win_q[i][4] <= col[i];
                        wv_q[i][4]  <= col_v[i];
                    end
                end
                w_v_q     <= push && tag_v;
                w_sof_q   <= push && tag_sof;
                w_eol_q   <= push && tag_eol;
                w_last_q  <= push && tag_last;
                x_v_q     <= w_v_q;
                x_sof_q   <= w_sof_q;
                x_eol_q   <= w_eol_q;
                x_last_q  <= w_last_q;
                mx_q      <= mx;
                m_valid_q <= x_v_q;
                m_sof_q   <= x_sof_q;
                m_eol_q   <= x_eol_q;
                m_last_q  <= x_last_q;
                m_data_q  <= mx_q;
            end
        end
    end

endmodule

// File: tb/tb_morph_dilate_5x5_stream.sv
// Scoreboard bench for morph_dilate_5x5_stream on an 8x6 frame.
// Expected pixels come from a direct 5x5 neighbourhood max/min over the frame.
module tb_morph_dilate_5x5_stream;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sof;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;
    logic       busy;
`ifdef MORPH_DILATE_GRADIENT_EN
    logic [7:0] m_grad;
`endif

    morph_dilate_5x5_stream #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
`ifdef MORPH_DILATE_GRADIENT_EN
        .m_grad  (m_grad),
`endif
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int sof;
        int eol;
        int g;
    } exp_t;

    exp_t   exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     rpct  = 100;
    int     out_n = 0;
    longint last_hs_t = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: randomised back-pressure, pop-and-compare on handshake.
    initial begin
        logic       held;
        logic [7:0] hd;
        exp_t       e;
        held    = 1'b0;
        hd      = '0;
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            m_ready = ($urandom_range(99) < rpct);
            #2;
            if (!rst_n || !m_valid) begin
                held = 1'b0;
            end else begin
                if (held) chk("stall_hold", m_data, hd);
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got data %0d, expected none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("data[%0d]", out_n), m_data, e.d);
                        chk($sformatf("sof[%0d]", out_n), m_sof, e.sof);
                        chk($sformatf("eol[%0d]", out_n), m_eol, e.eol);
`ifdef MORPH_DILATE_GRADIENT_EN
                        chk($sformatf("grad[%0d]", out_n), m_grad, e.g);
`endif
                        last_hs_t = $time;
                    end
                    out_n++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = m_data;
                end
            end
        end
    end

    task automatic drive_px(input int d, input logic sof, input int vpct,
                            output longint t_acc);
        int n;
        n     = 0;
        t_acc = -1;
        forever begin
            @(negedge clk);
            s_valid = ($urandom_range(99) < vpct);
            s_data  = 8'(d);
            s_sof   = sof;
            #1;
            if (s_valid && s_ready) begin
                t_acc = $time;
                break;
            end
            n++;
            if (n > 2000) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got no s_ready after %0d cycles, expected accept", n);
                break;
            end
        end
    endtask

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0: return (r == 3 && c == 3) ? 200 : 10;
            1: return (r == 0 && c == 0) ? 255 : 0;
            2: return r * 8 + c;
            3: return int'($urandom_range(255));
            default: return 50;
        endcase
    endfunction

    // Builds the frame, queues its 48 expected outputs, then sends npix pixels.
    task automatic send_frame(input int pat, input int vpct, input int npix,
                              output longint t_first);
        int     img[H][W];
        int     mx, mn, rr, cc, k;
        exp_t   e;
        longint t;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = pix(pat, r, c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                mx = 0;
                mn = 255;
                for (int dr = -2; dr <= 2; dr++) begin
                    for (int dc = -2; dc <= 2; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                            if (img[rr][cc] > mx) mx = img[rr][cc];
                            if (img[rr][cc] < mn) mn = img[rr][cc];
                        end
                    end
                end
                e.d   = mx;
                e.sof = (r == 0 && c == 0) ? 1 : 0;
                e.eol = (c == W - 1) ? 1 : 0;
                e.g   = mx - mn;
                exp_q.push_back(e);
            end
        end
        t_first = -1;
        k = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (k < npix) begin
                    drive_px(img[r][c], (r == 0 && c == 0), vpct, t);
                    if (k == 0) t_first = t;
                end
                k++;
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 2000) begin
            fails++;
            $display("FAIL %s_done: got %0d outputs pending after %0d cycles, expected 0",
                     name, exp_q.size(), n);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        longint tf;
        longint cyc;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_sof", m_sof, 0);
        chk("rst_m_eol", m_eol, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_frame(0, 100, 48, tf);
        wait_done("spot200");
        send_frame(1, 100, 48, tf);
        wait_done("corner255");

        send_frame(2, 100, 48, tf);
        wait_done("ramp");
        cyc = (last_hs_t - tf) / 10;
        tests++;
        if (cyc > 84) begin
            fails++;
            $display("FAIL ramp_cycles: got %0d cycles, expected <= 84", cyc);
        end

        rpct = 50;
        send_frame(2, 70, 48, tf);
        send_frame(3, 70, 48, tf);
        wait_done("ramp_stall_b2b");

        rpct = 100;
        send_frame(2, 100, 20, tf);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive_px(i + 1, 1'b0, 100, tf);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("nosof_dropped_busy", busy, 0);
        send_frame(2, 100, 48, tf);
        wait_done("ramp_after_rst");

        rpct = 60;
        send_frame(4, 80, 48, tf);
        wait_done("const50");
        send_frame(0, 80, 48, tf);
        wait_done("spot200_grad");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
